clk_rst_seq: RTL and testbench



---
 rtl/clk_rst_seq.sv | 147 ++++++++++++++
 tb/tb_clk_rst_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: divide-by-(cfg+1) clock-enable strobe, stretched downstream reset with
// reconfiguration sequenced through reset, and heartbeat. Optional macro: CLK_RST_SEQ_CFG_LOCK_EN.
module clk_rst_seq #(
  parameter int CFG_W      = 8,
  parameter int RST_CYCLES = 65535,
  parameter int RST_W      = 16,
  parameter int HB_PERIOD  = 12000000,
  parameter int HB_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] cfg_in,
  output logic             clk_en,
  output logic             div_phase,
  output logic             rst_out,
  output logic             hb,
  output logic [CFG_W-1:0] cfg_active
);

  localparam logic [RST_W-1:0] STRETCH_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [HB_W-1:0]  HB_LAST      = HB_W'(HB_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_STRETCH,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic [CFG_W-1:0] cfg_meta;
  logic [CFG_W-1:0] cfg_sync;
  logic [CFG_W-1:0] div_cnt;
  logic [CFG_W-1:0] div_cnt_nxt;
  logic [RST_W-1:0] stretch_cnt;
  logic [HB_W-1:0]  hb_cnt;
  logic             cfg_diff;
  logic             run_reconfig;
  logic             period_end;
  logic             stretch_done;
  logic             drain_done;
  logic             clk_en_nxt;

  // A switch moving between bits can present a torn value for one cycle; DRAIN abandons
  // cleanly when the value settles back before the period ends.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_meta <= '0;
      cfg_sync <= '0;
    end else begin
      cfg_meta <= cfg_in;
      cfg_sync <= cfg_meta;
    end
  end

  assign cfg_diff = (cfg_sync != cfg_active);

`ifdef CLK_RST_SEQ_CFG_LOCK_EN
  assign run_reconfig = 1'b0;
`else
  assign run_reconfig = cfg_diff;
`endif

  assign period_end   = (div_cnt == cfg_active);
  assign div_cnt_nxt  = period_end ? '0 : div_cnt + CFG_W'(1);
  assign stretch_done = (state == ST_STRETCH) && !cfg_diff && (stretch_cnt == STRETCH_LAST);
  assign drain_done   = (state == ST_DRAIN) && cfg_diff && period_end;

  // Next-cycle strobe, shared by the output register, div_phase and the heartbeat.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    clk_en_nxt = 1'b0;
    case (state)
      ST_STRETCH:       clk_en_nxt = stretch_done && (cfg_active == '0);
      ST_RUN, ST_DRAIN: clk_en_nxt = !drain_done && (div_cnt_nxt == cfg_active);
      default:          clk_en_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STRETCH;
      stretch_cnt <= '0;
      div_cnt     <= '0;
      cfg_active  <= '0;
      rst_out     <= 1'b1;
      clk_en      <= 1'b0;
      div_phase   <= 1'b0;
    end else begin
      clk_en    <= clk_en_nxt;
      div_phase <= drain_done ? 1'b0 : (div_phase ^ clk_en_nxt);
      case (state)
        ST_STRETCH: begin
          div_cnt <= '0;
          if (cfg_diff) begin
            cfg_active  <= cfg_sync;
            stretch_cnt <= '0;
          end else if (stretch_done) begin
            state   <= ST_RUN;
            rst_out <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt + RST_W'(1);
          end
        end
        ST_RUN: begin
          div_cnt <= div_cnt_nxt;
          if (run_reconfig) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The strobe of the closing period has already been issued when drain_done fires.
          if (drain_done) begin
            state       <= ST_STRETCH;
            cfg_active  <= cfg_sync;
            rst_out     <= 1'b1;
            stretch_cnt <= '0;
            div_cnt     <= '0;
          end else begin
            div_cnt <= div_cnt_nxt;
            if (!cfg_diff) state <= ST_RUN;
          end
        end
        default: begin
          state       <= ST_STRETCH;
          rst_out     <= 1'b1;
          stretch_cnt <= '0;
          div_cnt     <= '0;
        end
      endcase
    end
  end

  // Heartbeat survives reconfiguration; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (clk_en_nxt) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed self-checking bench for clk_rst_seq (CFG_W=4, RST_CYCLES=16, HB_PERIOD=4).
module tb_clk_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_in;
  logic       clk_en;
  logic       div_phase;
  logic       rst_out;
  logic       hb;
  logic [3:0] cfg_active;

  int checks = 0;
  int errors = 0;

  clk_rst_seq #(
    .CFG_W     (4),
    .RST_CYCLES(16),
    .RST_W     (16),
    .HB_PERIOD (4),
    .HB_W      (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_in    (cfg_in),
    .clk_en    (clk_en),
    .div_phase (div_phase),
    .rst_out   (rst_out),
    .hb        (hb),
    .cfg_active(cfg_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until clk_en is seen high; -1 on timeout. saw_rst flags any rst_out=1 on the way.
  task automatic wait_strobe(input int max, output int n, output logic saw_rst);
    n = 0;
    saw_rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (rst_out) saw_rst = 1'b1;
    end while (!clk_en && n < max);
    if (!clk_en) n = -1;
  endtask

  task automatic wait_rst(input logic level, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rst_out !== level && n < max);
    if (rst_out !== level) n = -1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst_out"}, int'(rst_out), 1);
    check({tag, "_clk_en"}, int'(clk_en), 0);
    check({tag, "_div_phase"}, int'(div_phase), 0);
    check({tag, "_hb"}, int'(hb), 0);
    check({tag, "_cfg_active"}, int'(cfg_active), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic s;
    int   en_cnt, dp_tg, hb_tg;
    logic dp_prev, hb_prev;

    // Test A: cfg=3 from time 0, rst for 3 edges.
    rst    = 1'b1;
    cfg_in = 4'd3;
    step(3);
    check_reset_values("por");
    rst = 1'b0;
    // 2 sync edges + 1 load edge (counter restarts) + 16 stretch edges = 19.
    wait_rst(1'b0, 60, n);
    check("a_stretch_len", n, 19);
    check("a_cfg_active", int'(cfg_active), 3);
    wait_strobe(20, n, s);
    check("a_first_strobe", n, 3);
    check("a_dp1", int'(div_phase), 1);
    step(1);
    check("a_strobe_width", int'(clk_en), 0);
    wait_strobe(20, n, s);
    check("a_spacing2", n, 3);
    check("a_dp2", int'(div_phase), 0);
    wait_strobe(20, n, s);
    check("a_spacing3", n, 4);
    check("a_hb_s3", int'(hb), 0);
    wait_strobe(20, n, s);
    check("a_spacing4", n, 4);
    check("a_hb_s4", int'(hb), 1);

`ifdef CLK_RST_SEQ_CFG_LOCK_EN
    // Lock: cfg change in RUN is ignored until rst.
    cfg_in = 4'd5;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(20, n, s);
      check("lk_spacing", n, 4);
      check("lk_no_rst", int'(s), 0);
    end
    check("lk_cfg_held", int'(cfg_active), 3);
    rst = 1'b1;
    step(1);
    check_reset_values("lk_rst");
    rst = 1'b0;
    wait_rst(1'b0, 60, n);
    check("lk_stretch_len", n, 19);
    check("lk_cfg_new", int'(cfg_active), 5);
    wait_strobe(20, n, s);
    check("lk_first_strobe", n, 5);
`else
    // Test B: 3->7->3 glitch just after a strobe; DRAIN abandoned, spacing stays 4.
    cfg_in = 4'd7;
    step(1);
    cfg_in = 4'd3;
    wait_strobe(20, n, s);
    check("b_glitch_spacing", n + 1, 4);
    check("b_no_rst", int'(s), 0);
    wait_strobe(20, n, s);
    check("b_spacing_after", n, 4);
    check("b_cfg_active", int'(cfg_active), 3);

    // Test C: rst in RUN, restart with cfg=5, then reconfigure to 1 mid-period.
    check("c_hb_before_rst", int'(hb), 1);
    rst    = 1'b1;
    cfg_in = 4'd5;
    step(1);
    check_reset_values("c_rst_run");
    rst = 1'b0;
    wait_rst(1'b0, 60, n);
    check("c_stretch_len", n, 19);
    wait_strobe(20, n, s);
    check("c_first_strobe", n, 5);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(20, n, s);
      check("c_spacing", n, 6);
    end
    check("c_hb_s4", int'(hb), 1);
    step(2);
    cfg_in = 4'd1;
    // Change lands at counter=1: the period still closes 6 cycles after the last strobe.
    wait_strobe(20, n, s);
    check("c_drain_spacing", n + 2, 6);
    check("c_drain_no_rst", int'(s), 0);
    check("c_drain_dp", int'(div_phase), 1);
    step(1);
    check("c_rst_rise", int'(rst_out), 1);
    check("c_rst_clk_en", int'(clk_en), 0);
    check("c_cfg_new", int'(cfg_active), 1);
    check("c_dp_cleared", int'(div_phase), 0);
    check("c_hb_held", int'(hb), 1);
    wait_rst(1'b0, 40, n);
    check("c_reconf_stretch", n, 16);
    check("c_hb_held_end", int'(hb), 1);
    wait_strobe(20, n, s);
    check("c_first_strobe_r2", n, 1);
    wait_strobe(20, n, s);
    check("c_spacing_r2", n, 2);
    check("c_hb_s7", int'(hb), 1);
    wait_strobe(20, n, s);
    check("c_spacing_r2b", n, 2);
    check("c_hb_s8", int'(hb), 0);

    // Test D: cfg=0 -> clk_en constantly high.
    cfg_in = 4'd0;
    wait_rst(1'b1, 20, n);
    check("d_drain_latency", n, 5);
    wait_rst(1'b0, 40, n);
    check("d_stretch_len", n, 16);
    check("d_clk_en_first", int'(clk_en), 1);
    check("d_dp_first", int'(div_phase), 1);
    en_cnt  = 0;
    dp_tg   = 0;
    hb_tg   = 0;
    dp_prev = div_phase;
    hb_prev = hb;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (clk_en) en_cnt++;
      if (div_phase != dp_prev) dp_tg++;
      if (hb != hb_prev) hb_tg++;
      dp_prev = div_phase;
      hb_prev = hb;
    end
    check("d_clk_en_cycles", en_cnt, 12);
    check("d_dp_toggles", dp_tg, 12);
    check("d_hb_toggles", hb_tg, 3);

    // Test E: cfg=15 (counter wraps 15->0), then rst while in DRAIN.
    cfg_in = 4'd15;
    wait_rst(1'b1, 20, n);
    check("e_drain_latency", n, 4);
    wait_rst(1'b0, 40, n);
    check("e_stretch_len", n, 16);
    wait_strobe(40, n, s);
    check("e_first_strobe", n, 15);
    wait_strobe(40, n, s);
    check("e_spacing1", n, 16);
    wait_strobe(40, n, s);
    check("e_spacing2", n, 16);
    check("e_cfg_active", int'(cfg_active), 15);
    cfg_in = 4'd2;
    step(5);
    check("e_drain_rst_out", int'(rst_out), 0);
    check("e_drain_clk_en", int'(clk_en), 0);
    rst = 1'b1;
    step(1);
    check_reset_values("e_rst_drain");
    rst = 1'b0;
    wait_rst(1'b0, 60, n);
    check("e_stretch_after_rst", n, 19);
    check("e_cfg_after_rst", int'(cfg_active), 2);
    wait_strobe(20, n, s);
    check("e_first_strobe_cfg2", n, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
